// File: rtl/frontend.sv
`default_nettype none
// ============================================================================
// Module   : frontend
// Purpose  : Multi-cycle RV32I fetch/decode sequencer (FETCH/EXEC/WB) that
//            drives backend ALU, memory and register-file controls.
// Revision : 1.0 - initial release
// ============================================================================
module frontend #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_data,
    input  logic [31:0] qa,
    input  logic        is_lt,
    input  logic        is_ltu,
    input  logic        is_zero,
    output logic [31:0] imem_addr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [7:0]  alu_op,
    output logic [7:0]  mem_op,
    output logic        load,
    output logic        store,
    output logic        alu_src_1,
    output logic        alu_src_2,
    output logic [31:0] alu_imm_1,
    output logic [31:0] alu_imm_2,
    output logic        reg_we,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP_REG    = 7'b0110011;
    localparam logic [6:0] C_OP_FENCE  = 7'b0001111;

    localparam logic [7:0] C_ALU_ADD = 8'b0000_0011;
    localparam logic [7:0] C_ALU_SUB = 8'b0000_0010;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [7:0]  w_arith_op;
    logic [7:0]  w_alu_op, w_mem_op;
    logic        w_load, w_store, w_src1, w_src2, w_writes, w_illegal, w_halt;
    logic [31:0] w_imm1, w_imm2;

    assign w_opcode   = r_ir[6:0];
    assign w_funct3   = r_ir[14:12];
    assign w_imm_i    = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s    = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b    = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u    = {r_ir[31:12], 12'b0};
    assign w_imm_j    = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_pc_plus4 = r_pc + 32'd4;

    assign imem_addr = r_pc;
    assign rs1       = r_ir[19:15];
    assign rs2       = r_ir[24:20];
    assign rd        = r_ir[11:7];

    // Shared OP / OP-IMM function decode; IR[30] selects SUB only for register ops.
    always_comb begin
        w_arith_op = '0;
        case (w_funct3)
            3'b000:  w_arith_op = (w_opcode == C_OP_REG && r_ir[30]) ? C_ALU_SUB : C_ALU_ADD;
            3'b001:  w_arith_op = 8'b0010_0000;
            3'b010:  w_arith_op = 8'b1000_0010;
            3'b011:  w_arith_op = 8'b0100_0010;
            3'b100:  w_arith_op = 8'b0000_0100;
            3'b101:  w_arith_op = r_ir[30] ? 8'b0000_1000 : 8'b0001_0000;
            3'b110:  w_arith_op = 8'b0000_0101;
            default: w_arith_op = 8'b0000_0110;
        endcase
    end

    always_comb begin
        w_alu_op  = '0;
        w_mem_op  = '0;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_src1    = 1'b0;
        w_src2    = 1'b0;
        w_imm1    = '0;
        w_imm2    = '0;
        w_writes  = 1'b0;
        w_illegal = 1'b0;
        w_target  = w_pc_plus4;
        case (w_opcode)
            C_OP_LUI: begin
                w_src1 = 1'b1; w_src2 = 1'b1; w_imm2 = w_imm_u;
                w_alu_op = C_ALU_ADD; w_writes = 1'b1;
            end
            C_OP_AUIPC: begin
                w_src1 = 1'b1; w_src2 = 1'b1; w_imm1 = r_pc; w_imm2 = w_imm_u;
                w_alu_op = C_ALU_ADD; w_writes = 1'b1;
            end
            C_OP_JAL: begin
                w_src1 = 1'b1; w_src2 = 1'b1; w_imm1 = r_pc; w_imm2 = 32'd4;
                w_alu_op = C_ALU_ADD; w_writes = 1'b1;
                w_target = r_pc + w_imm_j;
            end
            C_OP_JALR: begin
                w_src1 = 1'b1; w_src2 = 1'b1; w_imm1 = r_pc; w_imm2 = 32'd4;
                w_alu_op = C_ALU_ADD; w_writes = 1'b1;
                w_target = (qa + w_imm_i) & ~32'd1;
                w_illegal = (w_funct3 != 3'b000);
            end
            C_OP_BRANCH: begin
                w_alu_op = C_ALU_SUB;
                case (w_funct3)
                    3'b000:  w_target = is_zero  ? r_pc + w_imm_b : w_pc_plus4;
                    3'b001:  w_target = !is_zero ? r_pc + w_imm_b : w_pc_plus4;
                    3'b100:  w_target = is_lt    ? r_pc + w_imm_b : w_pc_plus4;
                    3'b101:  w_target = !is_lt   ? r_pc + w_imm_b : w_pc_plus4;
                    3'b110:  w_target = is_ltu   ? r_pc + w_imm_b : w_pc_plus4;
                    3'b111:  w_target = !is_ltu  ? r_pc + w_imm_b : w_pc_plus4;
                    default: w_illegal = 1'b1;
                endcase
            end
            C_OP_LOAD: begin
                w_src2 = 1'b1; w_imm2 = w_imm_i; w_alu_op = C_ALU_ADD;
                w_load = 1'b1; w_writes = 1'b1;
                case (w_funct3)
                    3'b000:  w_mem_op = 8'b1000_0000;
                    3'b001:  w_mem_op = 8'b0100_0000;
                    3'b010:  w_mem_op = 8'b0010_0000;
                    3'b100:  w_mem_op = 8'b0001_0000;
                    3'b101:  w_mem_op = 8'b0000_1000;
                    default: begin w_illegal = 1'b1; w_load = 1'b0; w_writes = 1'b0; end
                endcase
            end
            C_OP_STORE: begin
                w_src2 = 1'b1; w_imm2 = w_imm_s; w_alu_op = C_ALU_ADD; w_store = 1'b1;
                case (w_funct3)
                    3'b000:  w_mem_op = 8'b0000_0100;
                    3'b001:  w_mem_op = 8'b0000_0010;
                    3'b010:  w_mem_op = 8'b0000_0001;
                    default: begin w_illegal = 1'b1; w_store = 1'b0; end
                endcase
            end
            C_OP_IMM: begin
                w_src2 = 1'b1; w_alu_op = w_arith_op; w_writes = 1'b1;
                w_imm2 = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ?
                         {27'b0, r_ir[24:20]} : w_imm_i;
            end
            C_OP_REG: begin
                w_alu_op = w_arith_op; w_writes = 1'b1;
            end
            C_OP_FENCE: ;
            default:  w_illegal = 1'b1;
        endcase
    end

    // PC is always word aligned, so only a jump/branch can set bit 1.
    assign w_halt = w_illegal | w_target[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= NOP_WORD;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH) r_ir <= imem_data;
            if (r_state == S_WB)    r_pc <= w_target;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_op      = '0;
        mem_op      = '0;
        load        = 1'b0;
        store       = 1'b0;
        alu_src_1   = 1'b0;
        alu_src_2   = 1'b0;
        alu_imm_1   = '0;
        alu_imm_2   = '0;
        reg_we      = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: w_state_nxt = S_EXEC;
            S_EXEC, S_WB: begin
                alu_op    = w_alu_op;
                mem_op    = w_mem_op;
                load      = w_load;
                alu_src_1 = w_src1;
                alu_src_2 = w_src2;
                alu_imm_1 = w_imm1;
                alu_imm_2 = w_imm2;
                if (r_state == S_EXEC) begin
                    store       = w_store && !w_halt;
                    w_state_nxt = w_halt ? S_HALT : S_WB;
                end else begin
                    reg_we      = w_writes && (r_ir[11:7] != 5'd0);
                    w_state_nxt = S_FETCH;
                end
            end
            default: halted = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_frontend
// Purpose  : Scoreboard bench for frontend: directed instructions, expected
//            per-cycle values queued by stimulus and checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_data, qa;
    logic        is_lt, is_ltu, is_zero;
    logic [31:0] imem_addr, alu_imm_1, alu_imm_2;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  alu_op, mem_op;
    logic        load, store, alu_src_1, alu_src_2, reg_we, halted;

    frontend dut (
        .clk(clk), .rst(rst), .imem_data(imem_data), .qa(qa),
        .is_lt(is_lt), .is_ltu(is_ltu), .is_zero(is_zero),
        .imem_addr(imem_addr), .rs1(rs1), .rs2(rs2), .rd(rd),
        .alu_op(alu_op), .mem_op(mem_op), .load(load), .store(store),
        .alu_src_1(alu_src_1), .alu_src_2(alu_src_2),
        .alu_imm_1(alu_imm_1), .alu_imm_2(alu_imm_2),
        .reg_we(reg_we), .halted(halted)
    );

    always #5 clk = ~clk;

    localparam int S_PC = 0, S_REGWE = 1, S_STORE = 2, S_LOAD = 3, S_SRC1 = 4,
                   S_SRC2 = 5, S_IMM1 = 6, S_IMM2 = 7, S_ALUOP = 8, S_MEMOP = 9,
                   S_HALTED = 10, S_RD = 11, S_CTRL = 12;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } rec_t;

    rec_t sb[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    event sample_ev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act(input int s);
        case (s)
            S_PC:     return imem_addr;
            S_REGWE:  return {31'b0, reg_we};
            S_STORE:  return {31'b0, store};
            S_LOAD:   return {31'b0, load};
            S_SRC1:   return {31'b0, alu_src_1};
            S_SRC2:   return {31'b0, alu_src_2};
            S_IMM1:   return alu_imm_1;
            S_IMM2:   return alu_imm_2;
            S_ALUOP:  return {24'b0, alu_op};
            S_MEMOP:  return {24'b0, mem_op};
            S_HALTED: return {31'b0, halted};
            S_RD:     return {27'b0, rd};
            default:  return {23'b0, reg_we, store, load, alu_src_1, alu_src_2,
                              |alu_imm_1, |alu_imm_2, |alu_op, |mem_op};
        endcase
    endfunction

    function automatic string sname(input int s);
        case (s)
            S_PC: return "pc";         S_REGWE: return "reg_we";   S_STORE: return "store";
            S_LOAD: return "load";     S_SRC1: return "alu_src_1"; S_SRC2: return "alu_src_2";
            S_IMM1: return "alu_imm_1"; S_IMM2: return "alu_imm_2"; S_ALUOP: return "alu_op";
            S_MEMOP: return "mem_op";  S_HALTED: return "halted";  S_RD: return "rd";
            default: return "ctrl_any";
        endcase
    endfunction

    // Monitor: consume every expectation tagged with the current cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk or sample_ev);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                r = sb.pop_front();
                n_checks++;
                if (r.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL stale_%s cyc=%0d queued_for=%0d", sname(r.sig), cyc, r.cyc);
                end else if (act(r.sig) !== r.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d actual=%h expected=%h",
                             sname(r.sig), cyc, act(r.sig), r.val);
                end
            end
        end
    end

    task automatic exp(input int s, input logic [31:0] v);
        rec_t r;
        r.cyc = cyc; r.sig = s; r.val = v;
        sb.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
        exp(S_PC, pc); exp(S_CTRL, 32'd0); exp(S_HALTED, 32'd0);
        imem_data = ins;
        step();
        imem_data = 32'h0;
    endtask

    task automatic exec_chk(input logic s1, input logic s2, input logic [31:0] i1,
                            input logic [31:0] i2, input logic [7:0] aop,
                            input logic [7:0] mop, input logic st, input logic ld);
        exp(S_SRC1, {31'b0, s1}); exp(S_SRC2, {31'b0, s2});
        if (s1) exp(S_IMM1, i1);
        if (s2) exp(S_IMM2, i2);
        exp(S_ALUOP, {24'b0, aop}); exp(S_MEMOP, {24'b0, mop});
        exp(S_STORE, {31'b0, st}); exp(S_LOAD, {31'b0, ld});
        exp(S_REGWE, 32'd0); exp(S_HALTED, 32'd0);
        step();
    endtask

    task automatic wb_chk(input logic we, input logic [7:0] aop, input logic ld);
        exp(S_REGWE, {31'b0, we}); exp(S_STORE, 32'd0);
        exp(S_ALUOP, {24'b0, aop}); exp(S_LOAD, {31'b0, ld});
        step();
    endtask

    task automatic halt_chk(input logic [31:0] pc, input int n);
        for (int i = 0; i < n; i++) begin
            exp(S_HALTED, 32'd1); exp(S_PC, pc); exp(S_CTRL, 32'd0);
            step();
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        exp(S_PC, 32'h0); exp(S_CTRL, 32'd0); exp(S_HALTED, 32'd0); exp(S_RD, 32'd0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; imem_data = 32'h0; qa = 32'h0;
        is_lt = 1'b0; is_ltu = 1'b0; is_zero = 1'b0;
        step();
        reset_dut();

        // ADDI x1,x0,5
        fetch(32'h00500093, 32'h0);
        exp(S_RD, 32'd1);
        exec_chk(1'b0, 1'b1, 32'h0, 32'd5, 8'h03, 8'h00, 1'b0, 1'b0);
        exp(S_RD, 32'd1);
        wb_chk(1'b1, 8'h03, 1'b0);
        // SW x2,4(x1)
        fetch(32'h0020A223, 32'h4);
        exec_chk(1'b0, 1'b1, 32'h0, 32'd4, 8'h03, 8'h01, 1'b1, 1'b0);
        wb_chk(1'b0, 8'h03, 1'b0);
        // LW x3,8(x1)
        fetch(32'h0080A183, 32'h8);
        exec_chk(1'b0, 1'b1, 32'h0, 32'd8, 8'h03, 8'h20, 1'b0, 1'b1);
        wb_chk(1'b1, 8'h03, 1'b1);
        // FENCE
        fetch(32'h0000000F, 32'hC);
        exec_chk(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b0, 8'h00, 1'b0);
        // BEQ x1,x2,+8 taken
        is_zero = 1'b1;
        fetch(32'h00208463, 32'h10);
        exec_chk(1'b0, 1'b0, 32'h0, 32'h0, 8'h02, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b0, 8'h02, 1'b0);
        is_zero = 1'b0;
        // JAL x0,-8 back to the branch
        fetch(32'hFF9FF06F, 32'h18);
        exec_chk(1'b1, 1'b1, 32'h18, 32'd4, 8'h03, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b0, 8'h03, 1'b0);
        // BEQ not taken
        fetch(32'h00208463, 32'h10);
        exec_chk(1'b0, 1'b0, 32'h0, 32'h0, 8'h02, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b0, 8'h02, 1'b0);
        // JALR x1,8(x5), qa=0x101 -> 0x108
        qa = 32'h101;
        fetch(32'h008280E7, 32'h14);
        exec_chk(1'b1, 1'b1, 32'h14, 32'd4, 8'h03, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b1, 8'h03, 1'b0);
        // LUI x2,0x12345
        fetch(32'h12345137, 32'h108);
        exec_chk(1'b1, 1'b1, 32'h0, 32'h12345000, 8'h03, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b1, 8'h03, 1'b0);
        // AUIPC x3,1
        fetch(32'h00001197, 32'h10C);
        exec_chk(1'b1, 1'b1, 32'h10C, 32'h1000, 8'h03, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b1, 8'h03, 1'b0);
        // SUB x4,x1,x2
        fetch(32'h40208233, 32'h110);
        exec_chk(1'b0, 1'b0, 32'h0, 32'h0, 8'h02, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b1, 8'h02, 1'b0);
        // SRAI x5,x1,3
        fetch(32'h4030D293, 32'h114);
        exec_chk(1'b0, 1'b1, 32'h0, 32'd3, 8'h08, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b1, 8'h08, 1'b0);
        // SLTU x6,x1,x2
        fetch(32'h0020B333, 32'h118);
        exec_chk(1'b0, 1'b0, 32'h0, 32'h0, 8'h42, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b1, 8'h42, 1'b0);
        // BLT x1,x2,+8 taken
        is_lt = 1'b1;
        fetch(32'h0020C463, 32'h11C);
        exec_chk(1'b0, 1'b0, 32'h0, 32'h0, 8'h02, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b0, 8'h02, 1'b0);
        is_lt = 1'b0;
        // JALR with qa=0x103 -> target 0x10A misaligned -> HALT
        qa = 32'h103;
        fetch(32'h008280E7, 32'h124);
        exec_chk(1'b1, 1'b1, 32'h124, 32'd4, 8'h03, 8'h00, 1'b0, 1'b0);
        halt_chk(32'h124, 12);

        // Undefined word halts with PC frozen
        reset_dut();
        qa = 32'h0;
        fetch(32'hFFFFFFFF, 32'h0);
        exp(S_CTRL, 32'd0); exp(S_HALTED, 32'd0);
        step();
        halt_chk(32'h0, 11);

        // Reset asserted mid-WB drops reg_we without a clock edge
        reset_dut();
        fetch(32'h00500093, 32'h0);
        exec_chk(1'b0, 1'b1, 32'h0, 32'd5, 8'h03, 8'h00, 1'b0, 1'b0);
        exp(S_REGWE, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp(S_REGWE, 32'd0); exp(S_PC, 32'h0); exp(S_CTRL, 32'd0);
        #1;
        -> sample_ev;
        step();
        rst = 1'b1;
        fetch(32'h00500093, 32'h0);
        exec_chk(1'b0, 1'b1, 32'h0, 32'd5, 8'h03, 8'h00, 1'b0, 1'b0);
        wb_chk(1'b1, 8'h03, 1'b0);
        exp(S_PC, 32'h4); exp(S_CTRL, 32'd0);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frontend.md
FRONTEND -- requirements
Module: frontend

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_WORD, 32'h0000_0013, IR value loaded on reset (ADDI x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_data  input  32  instruction word at imem_addr, valid combinationally during FETCH.
REQ-006 qa  input  32  register-file read data for rs1, used for the JALR target.
REQ-007 is_lt, is_ltu, is_zero  input  1 each  backend compare flags for operand_a vs operand_b.
REQ-008 imem_addr  output  32  current PC.
REQ-009 rs1, rs2, rd  output  5 each  IR[19:15], IR[24:20], IR[11:7].
REQ-010 alu_op  output  8  {slt,sltu,sll,srl,sra,al[2:0]}; al is the 74x381 select: 000 clr, 010 A-B, 011 A+B, 100 xor, 101 or, 110 and.
REQ-011 mem_op  output  8  one-hot {lb,lh,lw,lbu,lhu,sb,sh,sw}.
REQ-012 load, store  output  1 each  memory read/write strobes.
REQ-013 alu_src_1, alu_src_2  output  1 each  1 = operand comes from alu_imm_1/alu_imm_2; 0 = comes from qa/qb.
REQ-014 alu_imm_1, alu_imm_2  output  32 each  immediate operands.
REQ-015 reg_we  output  1  register-file write enable.
REQ-016 halted  output  1  core stopped.

Function
REQ-017 FSM states: FETCH -> EXEC -> WB -> FETCH; HALT is absorbing.
REQ-018 FETCH: imem_addr=PC; IR<=imem_data at the clock edge that leaves FETCH; all control outputs 0.
REQ-019 EXEC and WB: controls decoded from IR and held stable across both cycles; reg_we=1 only in WB and only when rd!=0 for LUI/AUIPC/JAL/JALR/OP/OP-IMM/LOAD.
REQ-020 store=1 in EXEC only, for SB/SH/SW; load=1 in EXEC and WB, for LOADs.
REQ-021 LUI: imm1=0, imm2=U-imm, both src=1, al=011.
REQ-022 AUIPC: imm1=PC, imm2=U-imm, both src=1, al=011.
REQ-023 JAL/JALR: imm1=PC, imm2=4, both src=1, al=011 (link value).
REQ-024 OP-IMM: src1=0, src2=1, imm2=sign-extended I-imm; shifts use imm2=zero-extended shamt; SRAI when IR[30]=1.
REQ-025 OP: both src=0; SUB/SRA when IR[30]=1; SLT/SLTU assert the slt/sltu bit with al=010.
REQ-026 LOAD/STORE: src1=0, src2=1, imm2=I-imm or S-imm, al=011; mem_op per funct3.
REQ-027 BRANCH: both src=0, al=010; condition sampled in WB: BEQ is_zero, BNE !is_zero, BLT is_lt, BGE !is_lt, BLTU is_ltu, BGEU !is_ltu.
REQ-028 PC update occurs at the WB->FETCH edge only. Taken branch or JAL: PC+B/J-imm. JALR: (qa+I-imm)&~1. Otherwise PC+4. All arithmetic is modulo 2^32.
REQ-029 Undefined opcode, undefined funct3, ECALL, EBREAK, or a misaligned target (bit1 set): enter HALT at the EXEC->WB edge with no reg_we, no store, PC frozen, and halted=1 until reset.
REQ-030 FENCE executes as a NOP.

Reset
REQ-031 rst=0 forces immediately: state=FETCH, PC=RESET_PC, IR=NOP_WORD, halted=0, all control outputs 0, including mid-instruction; a pending store or reg_we is dropped.
REQ-032 First fetch occurs on the first rising edge after rst deasserts; deassertion is synchronised externally.

Verification
REQ-033 Reset, then imem_data=32'h00500093 (ADDI x1,x0,5): EXEC shows src1=0, src2=1, imm2=5, al=011; WB shows reg_we=1, rd=1; next FETCH has PC=4.
REQ-034 BEQ x1,x2,+8 at PC=0x10 with is_zero=1 -> PC=0x18; same instruction with is_zero=0 -> PC=0x14; reg_we stays 0 throughout.
REQ-035 JALR x1,8(x5) with qa=0x103 -> link imm1=PC, imm2=4; new PC=0x10A, so HALT with halted=1 (bit1 misaligned); qa=0x101 -> PC=0x108.
REQ-036 SW x2,4(x1): store=1 for exactly one cycle (EXEC), mem_op=8'b0000_0001, imm2=4, reg_we=0.
REQ-037 Drive rst low during WB of ADDI x1: reg_we drops combinationally, PC=RESET_PC, and no write occurs.
REQ-038 imem_data=32'hFFFFFFFF -> halted=1, PC unchanged for 10+ cycles, outputs 0.
